// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: state encoding,
// stage-control bundle and the load-use detect helper.
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_CACHE_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT   = 2'd2;

  localparam int WDOG_LIMIT_DEF = 255;
  localparam int STAT_W         = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic pc_redirect;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN  = stage_ctrl_t'(8'b11111_000);
  localparam stage_ctrl_t CTRL_HOLD = stage_ctrl_t'(8'b00000_000);

  function automatic logic load_use(input logic mem_read, input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs, input logic [4:0] id_rt);
    return mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, stage-control outputs and statistics of the pipeline controller.
interface pipeline_ctrl_if;
  logic        icache_miss, dcache_miss, cache_ready;
  logic        ex_mispredict, ex_mem_read, clr_stats;
  logic [31:0] EX_TARGET;
  logic [4:0]  EX_RT, ID_RS, ID_RT;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, pc_redirect;
  logic [31:0] REDIRECT_PC;
  logic        cache_timeout;
  logic [15:0] STALL_CYCLES, FLUSH_COUNT;

  modport master (
    output icache_miss, dcache_miss, cache_ready, ex_mispredict, ex_mem_read, clr_stats,
           EX_TARGET, EX_RT, ID_RS, ID_RT,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           pc_redirect, REDIRECT_PC, cache_timeout, STALL_CYCLES, FLUSH_COUNT
  );

  modport slave (
    input  icache_miss, dcache_miss, cache_ready, ex_mispredict, ex_mem_read, clr_stats,
           EX_TARGET, EX_RT, ID_RS, ID_RT,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
           pc_redirect, REDIRECT_PC, cache_timeout, STALL_CYCLES, FLUSH_COUNT
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter16.sv
// Statistics counter: saturating increment, synchronous clear wins over increment.
module sat_counter16
  import pipeline_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset || clr)
      count <= '0;
    else if (inc && (count != {STAT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect controller: cache-miss freeze, branch redirect,
// load-use bubble, watchdog on cache waits and stall/flush statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input logic            clk,
  input logic            reset,
  pipeline_ctrl_if.slave bus
);

  logic [1:0]  state, state_nxt;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [7:0]  wdog;
  logic        timeout_q;
  logic        miss, lu;
  stage_ctrl_t ctrl;
  logic [31:0] redirect_pc;

  assign miss = bus.icache_miss | bus.dcache_miss;
  assign lu   = load_use(bus.ex_mem_read, bus.EX_RT, bus.ID_RS, bus.ID_RT);

  // While in reset the defaults (RUN outputs, no redirect) stand and inputs are ignored.
  always_comb begin
    ctrl        = CTRL_RUN;
    redirect_pc = '0;
    state_nxt   = state;
    if (reset) begin
      case (state)
        ST_RUN: begin
          if (miss) begin
            ctrl      = CTRL_HOLD;
            state_nxt = ST_CACHE_WAIT;
          end else if (bus.ex_mispredict) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            ctrl.pc_redirect = 1'b1;
            redirect_pc      = bus.EX_TARGET;
          end else if (lu) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
          end
        end
        ST_CACHE_WAIT: begin
          ctrl = CTRL_HOLD;
          if (bus.cache_ready)
            state_nxt = pend_valid ? ST_REDIRECT : ST_RUN;
        end
        ST_REDIRECT: begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          ctrl.pc_redirect = 1'b1;
          redirect_pc      = pend_target;
          state_nxt        = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // A mispredict that coincides with a miss is parked and replayed after the fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      wdog        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_RUN: begin
          if (miss) begin
            wdog       <= '0;
            pend_valid <= bus.ex_mispredict;
            if (bus.ex_mispredict)
              pend_target <= bus.EX_TARGET;
          end
        end
        ST_CACHE_WAIT: begin
          if (wdog != 8'hFF)
            wdog <= wdog + 8'd1;
          if (int'(wdog) + 1 >= WDOG_LIMIT)
            timeout_q <= 1'b1;
        end
        ST_REDIRECT: pend_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  sat_counter16 u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr_stats),
    .inc   (~ctrl.pc_en),
    .count (bus.STALL_CYCLES)
  );

  sat_counter16 u_flush (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr_stats),
    .inc   (ctrl.pc_redirect),
    .count (bus.FLUSH_COUNT)
  );

  assign bus.pc_en         = ctrl.pc_en;
  assign bus.if_id_en      = ctrl.if_id_en;
  assign bus.id_ex_en      = ctrl.id_ex_en;
  assign bus.ex_mem_en     = ctrl.ex_mem_en;
  assign bus.mem_wb_en     = ctrl.mem_wb_en;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_flush   = ctrl.id_ex_flush;
  assign bus.pc_redirect   = ctrl.pc_redirect;
  assign bus.REDIRECT_PC   = redirect_pc;
  assign bus.cache_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: behavioural model checked every cycle plus directed
// literal expectations for the key scenarios, then randomized traffic.
module tb_pipeline_ctrl;

  localparam int LIM = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.WDOG_LIMIT(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Control bits ordered {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, pc_redirect}
  function automatic logic [7:0] dut_ctrl();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush, bus.pc_redirect};
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_live = 0, m_wait = 0, m_redir = 0, m_pend_v = 0, m_to = 0;
  logic [31:0] m_tgt = '0;
  int          m_wcnt = 0, m_stall = 0, m_flush = 0;

  function automatic void model_out(output logic [7:0] c, output logic [31:0] rpc);
    logic lu;
    lu  = bus.ex_mem_read && (bus.EX_RT != 5'd0) &&
          ((bus.EX_RT == bus.ID_RS) || (bus.EX_RT == bus.ID_RT));
    c   = 8'b11111_000;
    rpc = 32'h0;
    if (reset) begin
      if (m_redir) begin
        c = 8'b11111_111; rpc = m_tgt;
      end else if (m_wait || bus.icache_miss || bus.dcache_miss) begin
        c = 8'h00;
      end else if (bus.ex_mispredict) begin
        c = 8'b11111_111; rpc = bus.EX_TARGET;
      end else if (lu) begin
        c = 8'b00111_010;
      end
    end
  endfunction

  // Compare this cycle, then advance the model to what the next edge produces.
  always @(negedge clk) begin
    logic [7:0]  c;
    logic [31:0] r;
    model_out(c, r);
    if (m_live) begin
      chk("ctrl", {24'h0, dut_ctrl()}, {24'h0, c});
      chk("redirect_pc", bus.REDIRECT_PC, r);
      chk("cache_timeout", {31'h0, bus.cache_timeout}, {31'h0, m_to});
      chk("stall_cycles", {16'h0, bus.STALL_CYCLES}, 32'(m_stall));
      chk("flush_count", {16'h0, bus.FLUSH_COUNT}, 32'(m_flush));
    end
    if (!reset) begin
      m_live = 1; m_wait = 0; m_redir = 0; m_pend_v = 0; m_to = 0;
      m_tgt = '0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    end else if (m_live) begin
      if (bus.clr_stats) m_stall = 0;
      else if (!c[7] && m_stall < 65535) m_stall++;
      if (bus.clr_stats) m_flush = 0;
      else if (c[0] && m_flush < 65535) m_flush++;
      if (m_redir) begin
        m_redir = 0; m_pend_v = 0;
      end else if (m_wait) begin
        m_wcnt++;
        if (m_wcnt >= LIM) m_to = 1;
        if (bus.cache_ready) begin
          m_wait = 0; m_redir = m_pend_v;
        end
      end else if (bus.icache_miss || bus.dcache_miss) begin
        m_wait = 1; m_wcnt = 0; m_pend_v = bus.ex_mispredict;
        if (bus.ex_mispredict) m_tgt = bus.EX_TARGET;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    bus.icache_miss = 0; bus.dcache_miss = 0; bus.cache_ready = 0;
    bus.ex_mispredict = 0; bus.ex_mem_read = 0; bus.clr_stats = 0;
    bus.EX_TARGET = '0; bus.EX_RT = '0; bus.ID_RS = '0; bus.ID_RT = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    reset = 0;
    step(); step();
    // Reset: inputs ignored, RUN outputs
    bus.dcache_miss = 1; bus.ex_mispredict = 1; bus.EX_TARGET = 32'hDEAD0000;
    @(negedge clk);
    chk("rst_ctrl", {24'h0, dut_ctrl()}, 32'h000000F8);
    chk("rst_rpc", bus.REDIRECT_PC, 32'h0);
    chk("rst_stall", {16'h0, bus.STALL_CYCLES}, 32'h0);
    chk("rst_to", {31'h0, bus.cache_timeout}, 32'h0);
    step(); set_idle(); reset = 1;

    // Load-use
    bus.ex_mem_read = 1; bus.EX_RT = 5'd5; bus.ID_RS = 5'd5; bus.ID_RT = 5'd9;
    @(negedge clk) chk("lu_ctrl", {24'h0, dut_ctrl()}, 32'h0000003A);
    step(); set_idle();
    @(negedge clk) chk("lu_stall", {16'h0, bus.STALL_CYCLES}, 32'd1);
    bus.ex_mem_read = 1; bus.EX_RT = 5'd0; bus.ID_RS = 5'd0;
    @(negedge clk) chk("lu_r0_ctrl", {24'h0, dut_ctrl()}, 32'h000000F8);
    step(); set_idle();

    // Mispredict
    bus.ex_mispredict = 1; bus.EX_TARGET = 32'h00400040;
    @(negedge clk);
    chk("mp_ctrl", {24'h0, dut_ctrl()}, 32'h000000FF);
    chk("mp_rpc", bus.REDIRECT_PC, 32'h00400040);
    step(); set_idle();
    @(negedge clk) chk("mp_flush", {16'h0, bus.FLUSH_COUNT}, 32'd1);

    // Miss + mispredict together; mispredicts during the wait are ignored
    bus.dcache_miss = 1; bus.ex_mispredict = 1; bus.EX_TARGET = 32'h100;
    @(negedge clk) chk("mm_c0", {24'h0, dut_ctrl()}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(); set_idle();
      bus.ex_mispredict = 1; bus.EX_TARGET = 32'h200;
      bus.cache_ready = (i == 4);
      @(negedge clk) chk("mm_wait", {24'h0, dut_ctrl()}, 32'h0);
    end
    step(); set_idle();
    @(negedge clk);
    chk("mm_redir_ctrl", {24'h0, dut_ctrl()}, 32'h000000FF);
    chk("mm_redir_pc", bus.REDIRECT_PC, 32'h100);
    step();
    @(negedge clk);
    chk("mm_run_ctrl", {24'h0, dut_ctrl()}, 32'h000000F8);
    chk("mm_flush", {16'h0, bus.FLUSH_COUNT}, 32'd2);

    // Reset in the middle of a wait with a pending redirect
    bus.icache_miss = 1; bus.ex_mispredict = 1; bus.EX_TARGET = 32'h300;
    step(); set_idle(); step(); step();
    reset = 0;
    step(); reset = 1; bus.cache_ready = 1;
    @(negedge clk);
    chk("mr_ctrl", {24'h0, dut_ctrl()}, 32'h000000F8);
    chk("mr_stall", {16'h0, bus.STALL_CYCLES}, 32'h0);
    chk("mr_flush", {16'h0, bus.FLUSH_COUNT}, 32'h0);
    step(); set_idle();
    @(negedge clk) chk("mr_noredir", {24'h0, dut_ctrl()}, 32'h000000F8);

    // Watchdog, then a long wait to saturate the stall counter
    bus.dcache_miss = 1;
    step(); set_idle();
    repeat (254) @(posedge clk);
    @(negedge clk) chk("wd_254", {31'h0, bus.cache_timeout}, 32'h0);
    @(posedge clk);
    @(negedge clk) chk("wd_255", {31'h0, bus.cache_timeout}, 32'h1);
    repeat (65400) @(posedge clk);
    #1 bus.cache_ready = 1;
    @(negedge clk) chk("sat_hold", {16'h0, bus.STALL_CYCLES}, 32'h0000FFFF);
    step(); set_idle();
    @(negedge clk);
    chk("wd_sticky", {31'h0, bus.cache_timeout}, 32'h1);
    chk("sat_run", {16'h0, bus.STALL_CYCLES}, 32'h0000FFFF);
    bus.ex_mem_read = 1; bus.EX_RT = 5'd3; bus.ID_RT = 5'd3; bus.ID_RS = 5'd1; bus.clr_stats = 1;
    @(negedge clk) chk("clr_lu_ctrl", {24'h0, dut_ctrl()}, 32'h0000003A);
    step(); set_idle();
    @(negedge clk);
    chk("clr_stall", {16'h0, bus.STALL_CYCLES}, 32'h0);
    chk("clr_to_kept", {31'h0, bus.cache_timeout}, 32'h1);

    // Randomized traffic, model-checked every cycle
    reset = 0; step(); reset = 1;
    repeat (4000) begin
      step();
      reset             = ($urandom_range(99) != 0);
      bus.icache_miss   = ($urandom_range(99) < 3);
      bus.dcache_miss   = ($urandom_range(99) < 3);
      bus.cache_ready   = ($urandom_range(99) < 10);
      bus.ex_mispredict = ($urandom_range(99) < 15);
      bus.ex_mem_read   = ($urandom_range(99) < 40);
      bus.clr_stats     = ($urandom_range(99) < 2);
      bus.EX_TARGET     = $urandom;
      bus.EX_RT         = 5'($urandom_range(3));
      bus.ID_RS         = 5'($urandom_range(3));
      bus.ID_RT         = 5'($urandom_range(3));
    end
    step(); set_idle(); reset = 1;
    step();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
